// File: rtl/vpu_pkg.sv
// Shared types and constants for the serial subtractor datapath.
package vpu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Full_Subtractor.sv
// One-bit full subtractor: computes a - b - bin with borrow out.
module Full_Subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Plain combinational difference and borrow equations.
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one operand pair per operation, LSB first, one bit
// per clock, with a valid/ready handshake on both sides.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | shifting one bit per cycle through the full subtractor
// DONE  | result held on the outputs until the consumer takes it
module serial_subtractor
    import vpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_next;

    Full_Subtractor u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_borrow),
        .diff (w_d),
        .bout (w_bout)
    );

    // The new difference bit enters at the MSB; after WIDTH shifts the LSB
    // that was computed first has arrived at bit 0. Written as a shift/or so
    // it also holds for WIDTH = 1.
    assign w_diff_next = (r_diff >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    assign w_last      = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

    // Handshake flags come from the state; in_ready is additionally masked
    // while reset is held because the state register already reads IDLE then.
    assign in_ready   = (r_state == IDLE) && !rst;
    assign out_valid  = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_ovf;
    assign zero       = r_zero;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture in IDLE, shift in RUN, hold in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_diff   <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_zero <= ~|w_diff_next;
                        r_ovf  <= (r_a_msb != r_b_msb) &&
                                  (w_diff_next[WIDTH-1] != r_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor at WIDTH = 8 against
// an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         zero;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, unsigned and signed views.
    task automatic ref_sub(input int ua, input int ub,
                           output logic [W-1:0] e_diff, output logic e_bor,
                           output logic e_ovf, output logic e_zero);
        int sa, sb, s;
        e_diff = W'((ua - ub) & ((1 << W) - 1));
        e_bor  = (ua < ub);
        sa     = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb     = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        s      = sa - sb;
        e_ovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        e_zero = (e_diff == '0);
    endtask

    // One full operation: accept, measure latency, check result, optionally
    // stall the consumer, then release. With junk=1, in_valid is driven with
    // other operands throughout RUN/DONE to prove nothing is captured.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int stall, input bit junk, input string tag);
        logic [W-1:0] e_diff;
        logic         e_bor, e_ovf, e_zero;
        int           n;
        int           lat;
        ref_sub(int'(va), int'(vb), e_diff, e_bor, e_ovf, e_zero);

        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, in_ready, 1'b1);

        @(negedge clk);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (junk) begin
            a = ~va;
            b = va ^ 8'h3C;
        end else begin
            in_valid = 1'b0;
        end
        check({tag, "_busy"}, in_ready, 1'b0);

        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, lat, W);
        check({tag, "_diff"}, diff, e_diff);
        check({tag, "_borrow"}, borrow_out, e_bor);
        check({tag, "_ovf"}, overflow, e_ovf);
        check({tag, "_zero"}, zero, e_zero);

        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_ready"}, in_ready, 1'b0);
            check({tag, "_hold"}, {borrow_out, overflow, zero, diff},
                  {e_bor, e_ovf, e_zero, e_diff});
        end

        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           rose;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {out_valid, in_ready, borrow_out, overflow, zero, diff}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", in_ready, 1'b1);

        // Directed vectors.
        run_op(8'h05, 8'h03, 0, 1'b0, "d_5m3");
        check("d_5m3_diff_const", diff, 8'h02);
        run_op(8'h03, 8'h05, 1, 1'b0, "d_3m5");
        run_op(8'h80, 8'h01, 0, 1'b0, "d_80m1");
        run_op(8'h5A, 8'h5A, 2, 1'b0, "d_eq");

        // Consumer stall with competing input traffic, then a fresh op.
        run_op(8'hC3, 8'h47, 5, 1'b1, "stall");
        run_op(8'h7F, 8'hFF, 0, 1'b0, "after_stall");

        // Boundary operands.
        run_op(8'h00, 8'h00, 0, 1'b0, "b_zero");
        run_op(8'h00, 8'hFF, 0, 1'b0, "b_0mFF");
        run_op(8'h7F, 8'h80, 0, 1'b0, "b_7Fm80");

        // Randomized operations with random stalls and input noise.
        for (int k = 0; k < 30; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom), "rnd");
        end

        // Reset aborts an operation during the 4th RUN cycle.
        @(negedge clk);
        a = 8'h33;
        b = 8'h11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rose = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_rst_ready", in_ready, 1'b0);
        check("abort_in_rst_diff", diff, '0);
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_after", in_ready, 1'b1);
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        check("abort_no_valid", rose, 0);
        run_op(8'h10, 8'h01, 0, 1'b0, "post_abort");
        check("post_abort_diff_const", diff, 8'h0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
